ro_sum_counter: RTL

RO_SUM_COUNTER -- requirements
Module: ro_sum_counter

---
 rtl/ro_sum_counter.sv | 75 +++++++
 1 files changed

// File: rtl/ro_sum_counter.sv
// ro_sum_counter: ring-oscillator edge counter, N_AVG gate windows of WINDOW cycles summed into a 24-bit result
module ro_sum_counter #(
  parameter int WINDOW = 50000,
  parameter int N_AVG = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sum_en,
  input  logic        ro_in,
  input  logic [1:0]  send_sel,
  output logic        sum_ready,
  output logic [23:0] sum,
  output logic [7:0]  tx_byte
);
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, ACCUM, DONE} state_t;
  localparam logic [15:0] TIMER_LAST = 16'(WINDOW - 1);
  localparam logic [7:0] WIN_LAST = 8'(N_AVG - 1);
  state_t state, next;
  logic [2:0] sync;
  logic pulse;
  logic [15:0] edge_cnt, timer;
  logic [7:0] win_cnt;
  logic [23:0] acc, acc_sum;
  // sync[1] is the synchronized level, sync[2] its one-cycle-old copy
  assign pulse = sync[1] & ~sync[2];
  assign acc_sum = acc + {8'd0, edge_cnt};
  assign tx_byte = send_sel == 2'd0 ? sum[23:16] :
                   send_sel == 2'd1 ? sum[15:8] :
                   send_sel == 2'd2 ? sum[7:0] : 8'h00;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = sum_en ? CLEAR : IDLE;
      CLEAR:   next = sum_en ? GATE : IDLE;
      GATE:    next = !sum_en ? IDLE : (timer == TIMER_LAST ? ACCUM : GATE);
      ACCUM:   next = !sum_en ? IDLE : (win_cnt == WIN_LAST ? DONE : GATE);
      DONE:    next = sum_en ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      sum_ready <= 1'b0;
      sum <= '0;
      sync <= '0;
      edge_cnt <= '0;
      timer <= '0;
      win_cnt <= '0;
      acc <= '0;
    end else begin
      state <= next;
      sum_ready <= next == DONE;
      sync <= {sync[1:0], ro_in};
      if (state == CLEAR) begin
        acc <= '0;
        edge_cnt <= '0;
        win_cnt <= '0;
        timer <= '0;
      end
      if (state == GATE) begin
        timer <= timer + 16'd1;
        if (pulse) edge_cnt <= edge_cnt + 16'd1;
      end
      if (state == ACCUM) begin
        acc <= acc_sum;
        edge_cnt <= '0;
        timer <= '0;
        win_cnt <= win_cnt + 8'd1;
      end
      // an abort in ACCUM leaves sum untouched
      if (state == ACCUM && next == DONE) sum <= acc_sum;
    end
  end
endmodule
